// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: memory-stage initiator for the multi-cycle data memory.
// Decodes the memory operation, runs a req/ack handshake, returns valM and
// a final status code, and holds busy while the access is in flight.
// Optional feature macro: DMEM_TIMEOUT_EN (abort REQ after TIMEOUT cycles).
module dmem_access_ctrl #(
  parameter logic [63:0] ADDR_LIMIT = 64'd8191,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd3;
  localparam logic [2:0] STAT_HLT = 3'd4;

  // Status priority: halt, then address errors, then invalid instruction.
  function automatic logic [2:0] stat_f(input logic hlt, input logic adr, input logic inv);
    logic [2:0] s;
    if (hlt) begin
      s = STAT_HLT;
    end else if (adr) begin
      s = STAT_ADR;
    end else if (inv) begin
      s = STAT_INS;
    end else begin
      s = STAT_AOK;
    end
    return s;
  endfunction

  state_t      state_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [63:0] mem_addr_r;
  logic [63:0] mem_wdata_r;
  logic [63:0] val_m_r;
  logic [2:0]  stat_r;
  logic        busy_r;
  logic        done_r;
  // Status inputs captured at start, used when a REQ access completes.
  logic        hlt_r;
  logic        imem_err_r;
  logic        inv_r;

  logic        dec_access_s;
  logic        dec_we_s;
  logic [63:0] dec_addr_s;
  logic [63:0] dec_wdata_s;
  logic        dec_adr_err_s;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_r;
`endif

  // Decode the current instruction's memory operation.
  always_comb begin
    dec_access_s = 1'b0;
    dec_we_s     = 1'b0;
    dec_addr_s   = 64'd0;
    dec_wdata_s  = 64'd0;
    case (icode)
      4'd4, 4'd10: begin
        dec_access_s = 1'b1;
        dec_we_s     = 1'b1;
        dec_addr_s   = valE;
        dec_wdata_s  = valA;
      end
      4'd8: begin
        dec_access_s = 1'b1;
        dec_we_s     = 1'b1;
        dec_addr_s   = valE;
        dec_wdata_s  = valP;
      end
      4'd5: begin
        dec_access_s = 1'b1;
        dec_addr_s   = valE;
      end
      4'd9, 4'd11: begin
        dec_access_s = 1'b1;
        dec_addr_s   = valA;
      end
      default: begin
        dec_access_s = 1'b0;
      end
    endcase
    // Full 64-bit unsigned compare: high address bits are never dropped.
    dec_adr_err_s = dec_access_s && (dec_addr_s > ADDR_LIMIT);
  end

  // Access FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 64'd0;
      mem_wdata_r <= 64'd0;
      val_m_r     <= 64'd0;
      stat_r      <= STAT_AOK;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hlt_r       <= 1'b0;
      imem_err_r  <= 1'b0;
      inv_r       <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_r       <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r     <= 1'b1;
            hlt_r      <= (icode == 4'd0);
            imem_err_r <= imem_error;
            inv_r      <= ~instr_valid;
            if (dec_access_s && !dec_adr_err_s) begin
              state_r     <= REQ;
              mem_req_r   <= 1'b1;
              mem_we_r    <= dec_we_s;
              mem_addr_r  <= dec_addr_s;
              mem_wdata_r <= dec_wdata_s;
`ifdef DMEM_TIMEOUT_EN
              cnt_r       <= '0;
`endif
            end else begin
              // No access or out-of-range address: finish without a request.
              state_r <= DONE;
              done_r  <= 1'b1;
              stat_r  <= stat_f(icode == 4'd0, imem_error || dec_adr_err_s, ~instr_valid);
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we_r) begin
              val_m_r <= mem_rdata;
            end else begin
              val_m_r <= val_m_r;
            end
            state_r   <= DONE;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            done_r    <= 1'b1;
            stat_r    <= stat_f(hlt_r, imem_err_r, inv_r);
`ifdef DMEM_TIMEOUT_EN
          end else if (cnt_r == CNT_LAST) begin
            // Memory never answered: abandon the request as an address error.
            state_r   <= DONE;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            done_r    <= 1'b1;
            stat_r    <= stat_f(hlt_r, 1'b1, inv_r);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
`else
          end else begin
            mem_req_r <= 1'b1;
`endif
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign valM      = val_m_r;
  assign stat      = stat_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
